// File: rtl/tiny_dnn_pkg.sv
// Shared constants and state encoding for the tiny DNN core sequencer.
`timescale 1ns/1ps
package tiny_dnn_pkg;

  localparam int F_SIZE    = 1024;
  localparam int NCORE     = 16;
  localparam int DRAIN_CYC = 3;

  typedef enum logic [2:0] {
    IDLE,
    INIT,
    EXEC,
    BIAS,
    DRAIN,
    OUT,
    DONE
  } state_t;

endpackage

// File: rtl/tiny_dnn_seq_cnt.sv
// Loadable down-counter with a zero flag; saturates at zero instead of wrapping.
`timescale 1ns/1ps
module tiny_dnn_seq_cnt (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic [9:0] load_val,
  input  logic       dec,
  output logic       zero
);

  logic [9:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && cnt != 10'd0) begin
      cnt <= cnt - 10'd1;
    end
  end

  assign zero = (cnt == 10'd0);

endmodule

// File: rtl/tiny_dnn_seq.sv
// Sequencer for a chain of dot-product cores: init, exec terms, optional bias,
// pipeline drain and output shift, with a host weight-write port usable in IDLE.
`timescale 1ns/1ps
module tiny_dnn_seq #(
  parameter int F_SIZE = tiny_dnn_pkg::F_SIZE,
  parameter int NCORE  = tiny_dnn_pkg::NCORE
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [9:0]  len,
  input  logic        bank,
  input  logic        bias_en,
  output logic        busy,
  output logic        done,
  input  logic        hw_req,
  input  logic        hw_bias,
  input  logic [10:0] hw_addr,
  output logic        hw_gnt,
  output logic [9:0]  d_addr,
  output logic        init,
  output logic        write,
  output logic        bwrite,
  output logic        exec,
  output logic        outr,
  output logic        update,
  output logic        bias,
  output logic [10:0] ra,
  output logic [10:0] wa
);

  import tiny_dnn_pkg::*;

  localparam logic [9:0] LEN_MAX    = 10'(F_SIZE - 1);
  localparam logic [9:0] DRAIN_LAST = 10'(DRAIN_CYC - 1);
  localparam logic [9:0] OUT_LAST   = 10'(NCORE - 1);

  state_t     state, state_nxt;
  logic [9:0] len_q, len_eff;
  logic       bank_q, bias_en_q;
  logic [9:0] term, term_nxt;
  logic       cnt_load, cnt_dec, cnt_zero;
  logic [9:0] cnt_val;
  logic       host_ok;

  assign len_eff = (len == 10'd0) ? 10'd1 : ((len > LEN_MAX) ? LEN_MAX : len);

  tiny_dnn_seq_cnt u_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (cnt_load),
    .load_val (cnt_val),
    .dec      (cnt_dec),
    .zero     (cnt_zero)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Counter holds (cycles left in phase - 1); zero marks the last cycle.
  always_comb begin
    state_nxt = state;
    cnt_load  = 1'b0;
    cnt_val   = '0;
    cnt_dec   = 1'b0;
    term_nxt  = '0;
    case (state)
      IDLE:  if (start) state_nxt = INIT;
      INIT: begin
        state_nxt = EXEC;
        cnt_load  = 1'b1;
        cnt_val   = len_q - 10'd1;
      end
      EXEC: begin
        if (cnt_zero) begin
          if (bias_en_q) begin
            state_nxt = BIAS;
          end else begin
            state_nxt = DRAIN;
            cnt_load  = 1'b1;
            cnt_val   = DRAIN_LAST;
          end
        end else begin
          cnt_dec  = 1'b1;
          term_nxt = term + 10'd1;
        end
      end
      BIAS: begin
        state_nxt = DRAIN;
        cnt_load  = 1'b1;
        cnt_val   = DRAIN_LAST;
      end
      DRAIN: begin
        if (cnt_zero) begin
          state_nxt = OUT;
          cnt_load  = 1'b1;
          cnt_val   = OUT_LAST;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      OUT: begin
        if (cnt_zero) state_nxt = DONE;
        else          cnt_dec   = 1'b1;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Core controls are registered from the next state so they line up with it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      len_q     <= '0;
      bank_q    <= 1'b0;
      bias_en_q <= 1'b0;
      term      <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      init      <= 1'b0;
      exec      <= 1'b0;
      bias      <= 1'b0;
      outr      <= 1'b0;
      update    <= 1'b0;
      ra        <= '0;
      d_addr    <= '0;
    end else begin
      if (state == IDLE && start) begin
        len_q     <= len_eff;
        bank_q    <= bank;
        bias_en_q <= bias_en;
      end
      term   <= term_nxt;
      busy   <= state_nxt inside {INIT, EXEC, BIAS, DRAIN, OUT};
      done   <= (state_nxt == DONE);
      init   <= (state_nxt == INIT);
      exec   <= (state_nxt == EXEC);
      bias   <= (state_nxt == BIAS);
      outr   <= (state_nxt == OUT);
      update <= (state_nxt == OUT) && (state != OUT);
      ra     <= (state_nxt == EXEC || state_nxt == BIAS) ? {bank_q, term_nxt} : '0;
      d_addr <= (state_nxt == EXEC) ? term_nxt : '0;
    end
  end

  // Host writes pass straight through in IDLE; a same-cycle start wins.
  assign host_ok = rst_n && (state == IDLE) && hw_req && !start;
  assign hw_gnt  = host_ok;
  assign write   = host_ok;
  assign bwrite  = host_ok && hw_bias;
  assign wa      = host_ok ? hw_addr : '0;

endmodule

// File: tb/tb_tiny_dnn_seq.sv
// Scoreboard bench for tiny_dnn_seq: a behavioural core model accumulates
// weight*data from the control outputs and the monitor checks each pass at done.
`timescale 1ns/1ps
module tb_tiny_dnn_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [9:0]  len = '0;
  logic        bank = 1'b0;
  logic        bias_en = 1'b0;
  logic        hw_req = 1'b0;
  logic        hw_bias = 1'b0;
  logic [10:0] hw_addr = '0;
  logic        busy, done, hw_gnt, init, write, bwrite, exec, outr, update, bias;
  logic [9:0]  d_addr;
  logic [10:0] ra, wa;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int hw_data = 0;
  int w [2048];

  typedef struct {
    int sum;
    int dur;
    int nexec;
    int nbias;
    int bias_ra;
    int last_ra;
    int start_cyc;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  tiny_dnn_seq dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .len     (len),
    .bank    (bank),
    .bias_en (bias_en),
    .busy    (busy),
    .done    (done),
    .hw_req  (hw_req),
    .hw_bias (hw_bias),
    .hw_addr (hw_addr),
    .hw_gnt  (hw_gnt),
    .d_addr  (d_addr),
    .init    (init),
    .write   (write),
    .bwrite  (bwrite),
    .exec    (exec),
    .outr    (outr),
    .update  (update),
    .bias    (bias),
    .ra      (ra),
    .wa      (wa)
  );

  task automatic checkOutput(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Core model and monitor; data vector is x[i] = i + 1.
  int acc = 0, result = 0, n_exec = 0, n_bias = 0, bias_ra = 0, last_ra = 0;
  int first_exec = -1, n_out = 0, n_upd = 0, n_excl = 0;
  always begin
    @(negedge clk);
    #1;
    if (rst_n) begin
      if (write) begin
        if (bwrite) w[{wa[10], 10'h3FF}] = hw_data;
        else        w[wa] = hw_data;
      end
      if (init) begin
        acc = 0; n_exec = 0; n_bias = 0; bias_ra = 0; last_ra = 0;
        first_exec = -1; n_out = 0; n_upd = 0; n_excl = 0;
      end
      if ((int'(init) + int'(exec) + int'(bias)) > 1) n_excl++;
      if (exec) begin
        acc += w[ra] * (int'(d_addr) + 1);
        n_exec++;
        last_ra = int'(ra);
        if (first_exec < 0) first_exec = cyc;
      end
      if (bias) begin
        acc += w[{ra[10], 10'h3FF}];
        n_bias++;
        bias_ra = int'(ra);
      end
      if (outr) n_out++;
      if (update) begin
        n_upd++;
        result = acc;
      end
      if (done) begin
        checkOutput("done_expected", int'(sb.size() > 0), 1);
        if (sb.size() > 0) begin
          exp_t e;
          e = sb.pop_front();
          checkOutput("sum", result, e.sum);
          checkOutput("pass_cycles", cyc - e.start_cyc, e.dur);
          checkOutput("exec_count", n_exec, e.nexec);
          checkOutput("first_exec_cycle", first_exec - e.start_cyc, 2);
          checkOutput("last_exec_ra", last_ra, e.last_ra);
          checkOutput("bias_count", n_bias, e.nbias);
          checkOutput("bias_ra", bias_ra, e.bias_ra);
          checkOutput("outr_count", n_out, 16);
          checkOutput("update_count", n_upd, 1);
          checkOutput("ctrl_exclusive_viol", n_excl, 0);
        end
      end
    end
  end

  task automatic hostWrite(input logic [10:0] addr, input logic isb, input int data);
    @(negedge clk);
    hw_req = 1'b1; hw_addr = addr; hw_bias = isb; hw_data = data;
    #1;
    checkOutput("hw_gnt", int'(hw_gnt), 1);
    checkOutput("write", int'(write), 1);
    checkOutput("bwrite", int'(bwrite), int'(isb));
    checkOutput("wa", int'(wa), int'(addr));
    @(negedge clk);
    hw_req = 1'b0; hw_bias = 1'b0;
  endtask

  task automatic applyStimulus(input int l, input logic b, input logic be, input int esum,
                               input int edur, input int enexec, input int ebra,
                               input int elra, input bit push);
    exp_t e;
    @(negedge clk);
    len = 10'(l); bank = b; bias_en = be; start = 1'b1;
    e.sum = esum; e.dur = edur; e.nexec = enexec; e.nbias = int'(be);
    e.bias_ra = ebra; e.last_ra = elra; e.start_cyc = cyc;
    if (push) sb.push_back(e);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic waitDone(input int limit, input string name);
    bit got = 0;
    for (int k = 0; k < limit && !got; k++) begin
      @(negedge clk);
      #1;
      if (done) got = 1;
    end
    checkOutput(name, int'(got), 1);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bit got;
    int gnt_busy;
    bit found;

    for (int i = 0; i < 2048; i++) w[i] = 0;
    hw_req = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    checkOutput("reset_busy", int'(busy), 0);
    checkOutput("reset_done", int'(done), 0);
    checkOutput("reset_exec", int'(exec), 0);
    checkOutput("reset_hw_gnt", int'(hw_gnt), 0);
    checkOutput("reset_ra", int'(ra), 0);
    @(negedge clk);
    rst_n = 1'b1; hw_req = 1'b0;

    hostWrite(11'h000, 1'b0, 2);
    hostWrite(11'h001, 1'b0, 3);
    hostWrite(11'h002, 1'b0, 5);
    hostWrite(11'h003, 1'b0, 7);
    hostWrite(11'h005, 1'b0, 0);
    hostWrite(11'h400, 1'b0, 1);
    hostWrite(11'h401, 1'b0, 4);
    hostWrite(11'h402, 1'b0, 6);
    hostWrite(11'h400, 1'b1, 100);

    // 2*1 + 3*2 + 5*3 + 7*4 = 51, 1+4+3+16+1 = 25 cycles
    applyStimulus(4, 1'b0, 1'b0, 51, 25, 4, 0, 3, 1);
    waitDone(200, "done_len4");

    // 1*1 + 4*2 + 6*3 + bias 100 = 127, 1+3+1+3+16+1 = 25 cycles
    applyStimulus(3, 1'b1, 1'b1, 127, 25, 3, 11'h400, 11'h402, 1);
    waitDone(200, "done_len3_bias");

    // start and hw_req together: start wins, write waits for IDLE
    begin
      exp_t e;
      @(negedge clk);
      len = 10'd4; bank = 1'b0; bias_en = 1'b0; start = 1'b1;
      hw_req = 1'b1; hw_addr = 11'h405; hw_bias = 1'b0; hw_data = 9;
      e.sum = 51; e.dur = 25; e.nexec = 4; e.nbias = 0; e.bias_ra = 0; e.last_ra = 3;
      e.start_cyc = cyc;
      sb.push_back(e);
      #1;
      checkOutput("start_prio_gnt", int'(hw_gnt), 0);
      checkOutput("start_prio_write", int'(write), 0);
    end
    got = 0;
    gnt_busy = 0;
    for (int k = 0; k < 200 && !got; k++) begin
      @(negedge clk);
      start = (k == 5);
      if (k == 5) begin
        len = 10'd2; bias_en = 1'b1;
      end
      #1;
      if (hw_gnt) gnt_busy++;
      if (done) got = 1;
    end
    checkOutput("done_deferred_write", int'(got), 1);
    checkOutput("gnt_while_busy", gnt_busy, 0);
    @(negedge clk);
    #1;
    checkOutput("deferred_gnt", int'(hw_gnt), 1);
    checkOutput("deferred_write", int'(write), 1);
    checkOutput("deferred_wa", int'(wa), 11'h405);
    @(negedge clk);
    hw_req = 1'b0;

    // abort during term 2 of a 5-term pass
    applyStimulus(5, 1'b0, 1'b0, 0, 0, 0, 0, 0, 0);
    found = 0;
    for (int k = 0; k < 50 && !found; k++) begin
      @(negedge clk);
      #1;
      if (exec && ra == 11'd2) found = 1;
    end
    checkOutput("reached_term2", int'(found), 1);
    #1;
    rst_n = 1'b0; hw_req = 1'b1;
    #1;
    checkOutput("async_reset_ctrl",
                int'({busy, done, hw_gnt, init, write, bwrite, exec, outr, update, bias}), 0);
    checkOutput("async_reset_ra", int'(ra), 0);
    checkOutput("async_reset_daddr", int'(d_addr), 0);
    checkOutput("async_reset_wa", int'(wa), 0);
    @(negedge clk);
    rst_n = 1'b1; hw_req = 1'b0;
    applyStimulus(4, 1'b0, 1'b0, 51, 25, 4, 0, 3, 1);
    waitDone(200, "done_after_reset");

    // len=0 behaves as len=1: 2*1 = 2, 1+1+3+16+1 = 22 cycles
    applyStimulus(0, 1'b0, 1'b0, 2, 22, 1, 0, 0, 1);
    waitDone(200, "done_len0");

    // full-length pass: only w[0..3] are nonzero in bank 0
    applyStimulus(1023, 1'b0, 1'b0, 51, 1044, 1023, 0, 1022, 1);
    waitDone(1200, "done_len1023");

    repeat (2) @(negedge clk);
    checkOutput("scoreboard_empty", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
